result_display: RTL and testbench
=================================

# result_display

Output stage directly downstream of the CPU core. Captures the 8-bit result and carry when the core raises Halt, converts the 9-bit value (0–511) to three BCD digits with a sequential shift-add-3 engine, and drives a 4-digit, time-multiplexed, active-low 7-segment display. Runs continuously and re-captures on every new program completion.

## Interface
Parameters:
- REFRESH_DIV, 50000: clocks per digit slot; minimum 2.

Ports:
- Clock  in  1  system clock, rising edge.
- Reset  in  1  asynchronous, active-low; clears all state.
- Halt  in  1  core halt flag; a 0→1 transition triggers capture.
- Result  in  8  core Output bus.
- Carry  in  1  core cout; MSB of the captured value.
- Busy  out  1  high while converting.
- Valid  out  1  high when the digit registers hold the latest captured result.
- Seg  out  7  {g,f,e,d,c,b,a}, active-low.
- An  out  4  digit enables, active-low; An[0] is the ones digit.
- Dp  out  1  decimal point, active-low; held 1 (off).

## Operation
- Halt is registered as halt_q. A capture is requested when Halt=1 and halt_q=0.
- FSM states:
  - IDLE: entered from reset. All lit digits show dash (7'b0111111). A capture request loads {Carry,Result} into the shift register, clears the BCD accumulator and iteration count, sets Valid=0, and goes to CONV.
  - CONV: Busy=1. Each cycle, add 3 to every BCD nibble ≥5, then shift {bcd,bin} left by 1. After the 9th iteration, latch the hundreds, tens, and ones digits, set Valid=1, and go to SHOW.
  - SHOW: display the latched digits. A capture request behaves as in IDLE.
- Capture requests arriving in CONV are dropped and are not queued. Holding Halt high produces exactly one capture.
- Display contents:
  - Digit 3 is always blank (7'b1111111).
  - Hundreds digit is blank if 0.
  - Tens digit is blank if hundreds and tens are both 0.
  - Ones digit is always shown.
- While in CONV, the display keeps the previously latched digits, or dashes if no result has been latched since reset.
- Reset asserted at any time, including mid-conversion, immediately forces the reset values listed in Timing. No partial result survives.

## Timing
- Reset values: Busy=0, Valid=0, Seg=7'b1111111, An=4'b1111, Dp=1, state=IDLE, refresh count=0, digit index=3.
- Latency:
  - Edge E0: Halt is first sampled high and the value is loaded.
  - Edges E1–E9: the nine iterations run; Busy=1 between E0 and E9.
  - After E9: Valid=1 and Busy=0.
  - Total: 10 clocks from Halt sample to Valid.
- Refresh counter: counts 0 to REFRESH_DIV-1 and wraps. On each wrap:
  - The digit index advances 0→1→2→3→0, wrapping.
  - Seg and An are re-registered for the new index.
- Consequences of the refresh scheme:
  - The first digit (index 0) lights REFRESH_DIV clocks after reset release.
  - Exactly one An bit is low at any time after that.
  - Seg and An change on the same edge.
  - New digit values appear at the next slot boundary, never mid-slot.
- Scanning is independent of the FSM state.

## Structure
- Package display_pkg contains:
  - the state enum (IDLE, CONV, SHOW);
  - SEG_BLANK=7'b1111111 and SEG_DASH=7'b0111111;
  - NUM_DIGITS=4 and CONV_STEPS=9.
- Sub-module bcd_to_seg7 (combinational, 4-bit BCD → active-low 7-bit segments):
  - '0' = 7'b1000000;
  - '5' = 7'b0010010;
  - codes 10–15 map to SEG_BLANK.
  - Instantiate once, on the scan path.

## Test plan
- Reset low with Halt toggling → all outputs at reset values; no capture happens until Reset is high.
- REFRESH_DIV=4, Result=255, Carry=0, Halt pulse → Busy high for exactly 9 cycles; Valid high 10 clocks after the sample; scan shows blank, '2', '5', '5'; An cycles 1110, 1101, 1011, 0111 with 4 clocks each.
- Result=0, Carry=1 → digits '2', '5', '6' (256). Result=7, Carry=0 → hundreds and tens blank, ones '7'.
- Halt re-pulsed at E4 during CONV → ignored and the final value is unchanged. Halt held high for 200 cycles → exactly one Busy window.
- Second Halt pulse while in SHOW with Result=12 → Valid drops on the capture edge; the old digits persist until the new digits ('1', '2') latch.
- Reset asserted at E5 → Busy=0, Valid=0, Seg=7'h7F, An=4'hF immediately, with no clock needed; after release, dashes display until the next capture.

Source files
------------

// File: rtl/display_pkg.sv
// Shared types and constants for the result display path.
// Holds the FSM states, segment codes and BCD helpers.
package display_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CONV,
    SHOW
  } state_e;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;

  localparam int NUM_DIGITS = 4;
  localparam int CONV_STEPS = 9;

  // Double-dabble correction: every nibble >= 5 gets +3 before the shift
  function automatic logic [11:0] add3(input logic [11:0] b);
    logic [11:0] r;
    for (int i = 0; i < 3; i++) begin
      r[i*4 +: 4] = (b[i*4 +: 4] >= 4'd5) ? b[i*4 +: 4] + 4'd3
                                           : b[i*4 +: 4];
    end
    return r;
  endfunction

endpackage

// File: rtl/bcd_to_seg7.sv
// BCD digit to active-low 7-segment pattern {g,f,e,d,c,b,a}.
// Codes above 9 render as a blank digit.
module bcd_to_seg7
  import display_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    unique case (bcd)
      4'd0:    seg = 7'b1000000;
      4'd1:    seg = 7'b1111001;
      4'd2:    seg = 7'b0100100;
      4'd3:    seg = 7'b0110000;
      4'd4:    seg = 7'b0011001;
      4'd5:    seg = 7'b0010010;
      4'd6:    seg = 7'b0000010;
      4'd7:    seg = 7'b1111000;
      4'd8:    seg = 7'b0000000;
      4'd9:    seg = 7'b0010000;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/result_display.sv
// Captures the core result on Halt, converts it to BCD and
// scans it onto a 4-digit multiplexed 7-segment display.
module result_display
  import display_pkg::*;
#(
  parameter int REFRESH_DIV = 50000
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       Halt,
  input  logic [7:0] Result,
  input  logic       Carry,
  output logic       Busy,
  output logic       Valid,
  output logic [6:0] Seg,
  output logic [3:0] An,
  output logic       Dp
);

  localparam int CW = $clog2(REFRESH_DIV);

  state_e      state_q, state_d;
  logic        halt_q, halt_d;
  logic [8:0]  bin_q, bin_d;
  logic [11:0] bcd_q, bcd_d;
  logic [3:0]  step_q, step_d;
  logic [3:0]  hun_q, hun_d;
  logic [3:0]  ten_q, ten_d;
  logic [3:0]  one_q, one_d;
  logic        have_q, have_d;
  logic        valid_q, valid_d;
  logic [CW-1:0] rcnt_q, rcnt_d;
  logic [1:0]  idx_q, idx_d;
  logic [6:0]  seg_q, seg_d;
  logic [3:0]  an_q, an_d;

  logic        cap;
  logic        wrap;
  logic [1:0]  idx_nx;
  logic [3:0]  nib;
  logic [6:0]  dec_seg;
  logic [6:0]  seg_pick;

  always_comb begin
    state_d = state_q;
    halt_d  = Halt;
    bin_d   = bin_q;
    bcd_d   = bcd_q;
    step_d  = step_q;
    hun_d   = hun_q;
    ten_d   = ten_q;
    one_d   = one_q;
    have_d  = have_q;
    valid_d = valid_q;
    cap     = Halt & ~halt_q;
    unique case (state_q)
      IDLE, SHOW: begin
        if (cap) begin
          bin_d   = {Carry, Result};
          bcd_d   = '0;
          step_d  = '0;
          valid_d = 1'b0;
          state_d = CONV;
        end
      end
      CONV: begin
        {bcd_d, bin_d} = {add3(bcd_q), bin_q} << 1;
        step_d = step_q + 4'd1;
        if (step_q == 4'(CONV_STEPS - 1)) begin
          hun_d   = bcd_d[11:8];
          ten_d   = bcd_d[7:4];
          one_d   = bcd_d[3:0];
          have_d  = 1'b1;
          valid_d = 1'b1;
          state_d = SHOW;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Scan path: segment data is registered for the slot about to start
  always_comb begin
    wrap   = (rcnt_q == CW'(REFRESH_DIV - 1));
    rcnt_d = wrap ? '0 : rcnt_q + CW'(1);
    idx_nx = idx_q + 2'd1;
    idx_d  = idx_q;
    seg_d  = seg_q;
    an_d   = an_q;
    unique case (idx_nx)
      2'd0:    nib = one_q;
      2'd1:    nib = ten_q;
      2'd2:    nib = hun_q;
      default: nib = 4'hF;
    endcase
    seg_pick = dec_seg;
    if (idx_nx == 2'd3)
      seg_pick = SEG_BLANK;
    else if (!have_q)
      seg_pick = SEG_DASH;
    else if (idx_nx == 2'd2 && hun_q == 4'd0)
      seg_pick = SEG_BLANK;
    else if (idx_nx == 2'd1 && hun_q == 4'd0 && ten_q == 4'd0)
      seg_pick = SEG_BLANK;
    if (wrap) begin
      idx_d = idx_nx;
      seg_d = seg_pick;
      an_d  = ~(NUM_DIGITS'(1) << idx_nx);
    end
  end

  bcd_to_seg7 u_dec (
    .bcd (nib),
    .seg (dec_seg)
  );

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state_q <= IDLE;
      halt_q  <= 1'b0;
      bin_q   <= '0;
      bcd_q   <= '0;
      step_q  <= '0;
      hun_q   <= '0;
      ten_q   <= '0;
      one_q   <= '0;
      have_q  <= 1'b0;
      valid_q <= 1'b0;
      rcnt_q  <= '0;
      idx_q   <= 2'd3;
      seg_q   <= SEG_BLANK;
      an_q    <= 4'b1111;
    end else begin
      state_q <= state_d;
      halt_q  <= halt_d;
      bin_q   <= bin_d;
      bcd_q   <= bcd_d;
      step_q  <= step_d;
      hun_q   <= hun_d;
      ten_q   <= ten_d;
      one_q   <= one_d;
      have_q  <= have_d;
      valid_q <= valid_d;
      rcnt_q  <= rcnt_d;
      idx_q   <= idx_d;
      seg_q   <= seg_d;
      an_q    <= an_d;
    end
  end

  assign Busy  = (state_q == CONV);
  assign Valid = valid_q;
  assign Seg   = seg_q;
  assign An    = an_q;
  assign Dp    = 1'b1;

endmodule

// File: tb/tb_result_display.sv
// Self-checking bench for result_display with a short refresh
// period; expected displays flow through a scoreboard queue.
module tb_result_display;

  localparam int DIV = 4;

  logic       Clock = 1'b0;
  logic       Reset;
  logic       Halt;
  logic [7:0] Result;
  logic       Carry;
  logic       Busy;
  logic       Valid;
  logic [6:0] Seg;
  logic [3:0] An;
  logic       Dp;

  always #5 Clock = ~Clock;

  result_display #(.REFRESH_DIV(DIV)) dut (
    .Clock  (Clock),
    .Reset  (Reset),
    .Halt   (Halt),
    .Result (Result),
    .Carry  (Carry),
    .Busy   (Busy),
    .Valid  (Valid),
    .Seg    (Seg),
    .An     (An),
    .Dp     (Dp)
  );

  typedef logic [3:0][6:0] disp_t;

  typedef struct {
    logic       c;
    logic [7:0] r;
    int         h;
    int         t;
    int         o;
  } vec_t;

  int    n_run  = 0;
  int    n_fail = 0;
  disp_t sb[$];
  vec_t  vt[8];

  function automatic logic [6:0] seg_of(input int d);
    case (d)
      0: return 7'h40;
      1: return 7'h79;
      2: return 7'h24;
      3: return 7'h30;
      4: return 7'h19;
      5: return 7'h12;
      6: return 7'h02;
      7: return 7'h78;
      8: return 7'h00;
      9: return 7'h10;
      default: return 7'h7F;
    endcase
  endfunction

  function automatic disp_t mk(input int h, input int t, input int o);
    return {7'h7F, seg_of(h), seg_of(t), seg_of(o)};
  endfunction

  function automatic int idx_of(input logic [3:0] a);
    case (a)
      4'b1110: return 0;
      4'b1101: return 1;
      4'b1011: return 2;
      4'b0111: return 3;
      default: return -1;
    endcase
  endfunction

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  task automatic scan_check(input disp_t e);
    logic [3:0] prev;
    int run;
    int id;
    repeat (DIV + 2) @(negedge Clock);
    prev = An;
    run  = -1;
    chk("dp_off", 32'(Dp), 32'd1);
    for (int s = 0; s < 8 * DIV; s++) begin
      @(negedge Clock);
      if (An != prev) begin
        chk("an_order", 32'(An), 32'({prev[2:0], prev[3]}));
        if (run >= 0) chk("slot_len", run, DIV);
        run  = 1;
        prev = An;
      end else if (run >= 0) begin
        run++;
      end
      id = idx_of(An);
      if (id < 0) chk("an_onehot", 32'(An), 32'hE);
      else chk($sformatf("seg_d%0d", id), 32'(Seg), 32'(e[id]));
    end
  endtask

  task automatic pop_scan();
    if (sb.size() == 0) chk("sb_empty", 0, 1);
    else scan_check(sb.pop_front());
  endtask

  task automatic capture(input logic c, input logic [7:0] r,
                         input disp_t e, input int repulse,
                         input bit chk_old, input disp_t oldv);
    int busy_n;
    int vk;
    int id;
    @(negedge Clock);
    Carry  = c;
    Result = r;
    Halt   = 1'b1;
    sb.push_back(e);
    busy_n = 0;
    vk     = 0;
    for (int k = 1; k <= 30 && vk == 0; k++) begin
      @(negedge Clock);
      if (k == 1) chk("valid_drop", 32'(Valid), 32'd0);
      if (Busy) busy_n++;
      if (chk_old && Busy) begin
        id = idx_of(An);
        if (id >= 0) chk("old_persist", 32'(Seg), 32'(oldv[id]));
      end
      if (Valid) vk = k;
      if (k == 1) Halt = 1'b0;
      if (repulse > 0 && k == repulse) Halt = 1'b1;
      if (repulse > 0 && k == repulse + 1) Halt = 1'b0;
    end
    Halt = 1'b0;
    chk("busy_cycles", busy_n, 9);
    chk("valid_latency", vk, 10);
    pop_scan();
  endtask

  initial begin
    int first;
    int nb;
    logic pb;
    disp_t dash;

    dash  = {7'h7F, 7'h3F, 7'h3F, 7'h3F};
    vt[0] = '{1'b0, 8'd255, 2, 5, 5};
    vt[1] = '{1'b1, 8'd0, 2, 5, 6};
    vt[2] = '{1'b0, 8'd7, 10, 10, 7};
    vt[3] = '{1'b1, 8'd255, 5, 1, 1};
    vt[4] = '{1'b0, 8'd100, 1, 0, 0};
    vt[5] = '{1'b0, 8'd10, 10, 1, 0};
    vt[6] = '{1'b0, 8'd0, 10, 10, 0};
    vt[7] = '{1'b0, 8'd99, 10, 9, 9};

    Reset  = 1'b0;
    Halt   = 1'b0;
    Carry  = 1'b0;
    Result = 8'd0;

    for (int i = 0; i < 6; i++) begin
      @(negedge Clock);
      chk("rst_busy", 32'(Busy), 32'd0);
      chk("rst_valid", 32'(Valid), 32'd0);
      chk("rst_seg", 32'(Seg), 32'h7F);
      chk("rst_an", 32'(An), 32'hF);
      chk("rst_dp", 32'(Dp), 32'd1);
      Halt   = ~Halt;
      Result = 8'(i * 37);
    end

    @(negedge Clock);
    Halt  = 1'b0;
    Reset = 1'b1;
    first = 0;
    for (int k = 1; k <= 3 * DIV && first == 0; k++) begin
      @(negedge Clock);
      if (An != 4'hF) first = k;
    end
    chk("first_lit", first, DIV);
    chk("no_cap_busy", 32'(Busy), 32'd0);
    chk("no_cap_valid", 32'(Valid), 32'd0);
    scan_check(dash);

    for (int i = 0; i < 8; i++)
      capture(vt[i].c, vt[i].r, mk(vt[i].h, vt[i].t, vt[i].o),
              0, 1'b0, '0);

    capture(1'b0, 8'd200, mk(2, 0, 0), 4, 1'b0, '0);

    @(negedge Clock);
    Carry  = 1'b0;
    Result = 8'd123;
    Halt   = 1'b1;
    sb.push_back(mk(1, 2, 3));
    nb = 0;
    pb = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge Clock);
      if (Busy && !pb) nb++;
      pb = Busy;
    end
    chk("busy_windows", nb, 1);
    chk("held_valid", 32'(Valid), 32'd1);
    Halt = 1'b0;
    pop_scan();

    capture(1'b0, 8'd12, mk(10, 1, 2), 0, 1'b1, mk(1, 2, 3));

    @(negedge Clock);
    Carry  = 1'b0;
    Result = 8'd99;
    Halt   = 1'b1;
    @(posedge Clock);
    @(negedge Clock);
    Halt = 1'b0;
    repeat (5) @(posedge Clock);
    #1;
    chk("pre_rst_busy", 32'(Busy), 32'd1);
    #1 Reset = 1'b0;
    #1;
    chk("mid_rst_busy", 32'(Busy), 32'd0);
    chk("mid_rst_valid", 32'(Valid), 32'd0);
    chk("mid_rst_seg", 32'(Seg), 32'h7F);
    chk("mid_rst_an", 32'(An), 32'hF);
    chk("mid_rst_dp", 32'(Dp), 32'd1);
    @(negedge Clock);
    Reset = 1'b1;
    repeat (12) @(negedge Clock);
    chk("post_rst_busy", 32'(Busy), 32'd0);
    chk("post_rst_valid", 32'(Valid), 32'd0);
    scan_check(dash);

    capture(1'b0, 8'd42, mk(10, 4, 2), 0, 1'b0, '0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
